// File: rtl/rr_arbiter_n.sv
// N-way arbiter with round-robin / fixed-priority selection and bounded
// per-requester grant locking. All outputs are registered.
module rr_arbiter_n #(
  parameter  int unsigned N        = 4,
  parameter  int unsigned HOLD_MAX = 8,
  localparam int unsigned IDW      = $clog2(N)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   req,
  input  logic [N-1:0]   lock,
  input  logic           mode,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] gnt_id,
  output logic           gnt_valid,
  output logic           timeout
);

  localparam int unsigned CW = $clog2(HOLD_MAX + 1);

  logic [IDW-1:0] ptr, cur;
  logic [CW-1:0]  hold_cnt;

  logic [N-1:0]   gnt_n;
  logic [IDW-1:0] gnt_id_n, ptr_n, cur_n, pick, idx;
  logic [CW-1:0]  hold_n;
  logic           gnt_valid_n, timeout_n, locked, found;
  logic [N-1:0]   elig;

  // Next-state: hold an active lock, or arbitrate (masking the owner on forced release)
  always_comb begin
    gnt_n       = '0;
    gnt_id_n    = '0;
    gnt_valid_n = 1'b0;
    timeout_n   = 1'b0;
    ptr_n       = ptr;
    cur_n       = cur;
    hold_n      = '0;
    elig        = req;
    found       = 1'b0;
    pick        = '0;
    idx         = '0;
    locked      = gnt_valid && req[cur] && lock[cur];

    if (locked && (hold_cnt < CW'(HOLD_MAX))) begin
      gnt_n       = gnt;
      gnt_id_n    = gnt_id;
      gnt_valid_n = 1'b1;
      hold_n      = hold_cnt + CW'(1);
    end else begin
      if (locked) begin
        elig[cur] = 1'b0;
        timeout_n = 1'b1;
      end
      // Scan in reverse so the first index in priority order wins last
      if (mode) begin
        for (int i = int'(N) - 1; i >= 0; i--) begin
          if (elig[IDW'(i)]) begin
            found = 1'b1;
            pick  = IDW'(i);
          end
        end
      end else begin
        for (int i = int'(N) - 1; i >= 0; i--) begin
          idx = IDW'((int'(ptr) + i) % int'(N));
          if (elig[idx]) begin
            found = 1'b1;
            pick  = idx;
          end
        end
      end
      if (found) begin
        gnt_n       = N'(1) << pick;
        gnt_id_n    = pick;
        gnt_valid_n = 1'b1;
        cur_n       = pick;
        hold_n      = CW'(1);
        ptr_n       = (pick == IDW'(N - 1)) ? '0 : pick + IDW'(1);
      end
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      gnt       <= '0;
      gnt_id    <= '0;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
      ptr       <= '0;
      cur       <= '0;
      hold_cnt  <= '0;
    end else begin
      gnt       <= gnt_n;
      gnt_id    <= gnt_id_n;
      gnt_valid <= gnt_valid_n;
      timeout   <= timeout_n;
      ptr       <= ptr_n;
      cur       <= cur_n;
      hold_cnt  <= hold_n;
    end
  end

endmodule

// File: doc/rr_arbiter_n.md
# rr_arbiter_n

Parametrised N-way arbiter, the successor to the 3-request round-robin arbiter. It accepts N request lines and issues a registered one-hot grant each cycle. It supports two selection modes, round-robin and fixed-priority, plus a per-requester lock that holds a grant across a multi-cycle transaction up to a bounded hold limit. It sits between bus masters and a shared resource and is reused wherever more than three requesters contend.

## Interface
- N, default 4: number of requesters; legal range N >= 2.
- HOLD_MAX, default 8: maximum consecutive cycles a locked grant may be held; legal range HOLD_MAX >= 1.
- IDW, default $clog2(N): width of gnt_id. Derived; never overridden.

- clk  input  1  rising-edge clock; the only clock.
- reset  input  1  synchronous, active-high reset.
- req  input  N  request vector; bit i = requester i wants the resource.
- lock  input  N  bit i = requester i asks to keep its grant next cycle; only meaningful while req[i]=1.
- mode  input  1  0 = round-robin, 1 = fixed priority (lowest index wins).
- gnt  output  N  registered one-hot grant, or all-zero when idle.
- gnt_id  output  IDW  binary index of the granted bit; 0 when idle.
- gnt_valid  output  1  OR of gnt.
- timeout  output  1  one-cycle pulse when a locked grant is forcibly revoked at HOLD_MAX.

## Operation
- Internal state:
  - ptr (IDW bits): search start for round-robin.
  - cur (IDW bits): last granted index.
  - hold_cnt (clog2(HOLD_MAX+1) bits): cycles the current grant has been held.
- Reset clears gnt, gnt_id, gnt_valid, timeout, ptr, cur and hold_cnt to 0. Reset has priority over every other input.
- Each rising edge evaluates req, lock and mode sampled at that edge. Decisions are made in this order:
  1. **Hold.** If gnt_valid=1, req[cur]=1, lock[cur]=1 and hold_cnt < HOLD_MAX:
     - gnt is unchanged.
     - hold_cnt increments.
     - ptr is unchanged.
  2. **Forced release.** If gnt_valid=1, req[cur]=1, lock[cur]=1 and hold_cnt == HOLD_MAX:
     - timeout=1.
     - Arbitrate as in step 3, but with req[cur] masked for this evaluation only.
  3. **Arbitrate.**
     - Round-robin (mode=0): scan indices ptr, ptr+1, …, N-1, 0, …, ptr-1 (modulo N). Grant the first index with req=1.
     - Fixed priority (mode=1): grant the lowest index with req=1.
- After a new grant to index k in step 2 or 3:
  - gnt = one-hot k, gnt_id = k, cur = k.
  - hold_cnt = 1.
  - ptr = (k+1) mod N, updated in both modes.
  - The previous requester may be regranted in step 3 if it is the sole requester, except in the masked step-2 case.
- If no eligible request exists:
  - gnt = 0, gnt_id = 0, gnt_valid = 0, hold_cnt = 0.
  - ptr and cur keep their values.
- Without lock, a requester holding req high yields every cycle to the next requester in round-robin order.
- lock[i] with req[i]=0 is ignored. lock on a non-granted index is ignored.
- A mode change takes effect at the next edge. It does not break an active hold.
- timeout is 0 in every cycle except the one following a forced release.

## Timing
- Latency: req sampled at edge t produces gnt visible after edge t; one-cycle registered latency. There is no combinational path from req to gnt.
- Dropping req[cur] at edge t removes or moves the grant after edge t. The resource owner sees at most one grant cycle after deassert.
- gnt_id, gnt_valid and timeout update on the same edge as gnt and are mutually consistent.
- Maximum continuous ownership under lock is HOLD_MAX cycles. A held grant survives reset only until the reset edge.
- Asserting reset mid-hold clears the grant on that edge. The first edge after reset is released arbitrates from ptr=0.

## Test plan
All scenarios use N=4, HOLD_MAX=3 unless stated.
1. **Reset and idle.** Hold reset 2 cycles, then release with req=0000 -> gnt=0000, gnt_id=0, gnt_valid=0, timeout=0.
2. **Single requests.** req=0001, then 0010, then 1000, one cycle each -> gnt=0001, 0010, 1000 on successive cycles. Then req=0000 -> gnt=0000.
3. **Round-robin rotation.** After reset, req=1111 held for 5 cycles -> gnt=0001, 0010, 0100, 1000, 0001. Then req=0000 for 1 cycle, then req=0110 -> gnt=0010, 0100, 0010.
4. **Fixed priority.** mode=1, req=1110 held for 3 cycles -> gnt=0010 every cycle. Switch mode=0 -> next grant is 0100.
5. **Lock and timeout.** req=0011, lock=0001 held continuously:
   - gnt=0001 for 3 cycles, timeout=0.
   - Then gnt=0010 with timeout=1 for exactly that cycle.
   - Then gnt=0001 again with hold_cnt=1.
   - Repeat with req=0001, lock=0001 -> after 3 cycles gnt=0000 and timeout=1 for one cycle, then gnt=0001.
6. **Reset mid-hold.** While a lock is active on index 2, pulse reset for 1 cycle -> gnt=0000 on that edge. Afterwards, req=1111 -> gnt=0001.
